// File: rtl/ahb_bridge_arbiter_if.sv
`default_nettype none
// ============================================================================
// ahb_bridge_arbiter_if : two-master AHB-Lite request side plus muxed bridge port
// Revision: 1.0
// ============================================================================
interface ahb_bridge_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  HBUSREQ_M0, HBUSREQ_M1;
  logic [1:0]            HTRANS_M0,  HTRANS_M1;
  logic [ADDR_WIDTH-1:0] HADDR_M0,   HADDR_M1;
  logic                  HWRITE_M0,  HWRITE_M1;
  logic [2:0]            HSIZE_M0,   HSIZE_M1;
  logic [2:0]            HBURST_M0,  HBURST_M1;
  logic [DATA_WIDTH-1:0] HWDATA_M0,  HWDATA_M1;
  logic                  HGRANT_M0,  HGRANT_M1;
  logic                  HMASTER;
  logic                  HSEL;
  logic [1:0]            HTRANS;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADYIN;
  logic                  HREADYOUT;

  // Arbiter side
  modport slave (
    input  HBUSREQ_M0, HBUSREQ_M1, HTRANS_M0, HTRANS_M1, HADDR_M0, HADDR_M1,
           HWRITE_M0, HWRITE_M1, HSIZE_M0, HSIZE_M1, HBURST_M0, HBURST_M1,
           HWDATA_M0, HWDATA_M1, HREADYOUT,
    output HGRANT_M0, HGRANT_M1, HMASTER, HSEL, HTRANS, HADDR, HWRITE,
           HSIZE, HBURST, HWDATA, HREADYIN
  );

  // Masters and bridge side
  modport master (
    output HBUSREQ_M0, HBUSREQ_M1, HTRANS_M0, HTRANS_M1, HADDR_M0, HADDR_M1,
           HWRITE_M0, HWRITE_M1, HSIZE_M0, HSIZE_M1, HBURST_M0, HBURST_M1,
           HWDATA_M0, HWDATA_M1, HREADYOUT,
    input  HGRANT_M0, HGRANT_M1, HMASTER, HSEL, HTRANS, HADDR, HWRITE,
           HSIZE, HBURST, HWDATA, HREADYIN
  );
endinterface
`default_nettype wire

// File: rtl/ahb_bridge_arbiter.sv
`default_nettype none
// ============================================================================
// ahb_bridge_arbiter : two-master AHB-Lite arbiter in front of the AHB-to-APB
// bridge; ARB_FIXED_PRIO_EN selects fixed master-0 priority over round-robin.
// Revision: 1.0
// ============================================================================
module ahb_bridge_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DEFAULT_MASTER = 0
) (
  input wire logic            HCLK,
  input wire logic            HRESET,
  ahb_bridge_arbiter_if.slave bus
);
  localparam logic c_DEF_MASTER = (DEFAULT_MASTER != 0);

  logic                  grant_q, grant_d;
  logic                  hmaster_q, hmaster_d;
  logic                  w_boundary;
  logic                  w_next_owner;
  logic [1:0]            w_trans;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_write;
  logic [2:0]            w_size;
  logic [2:0]            w_burst;
  logic [DATA_WIDTH-1:0] w_wdata;

  always_comb begin
    w_trans = bus.HTRANS_M0;
    w_addr  = bus.HADDR_M0;
    w_write = bus.HWRITE_M0;
    w_size  = bus.HSIZE_M0;
    w_burst = bus.HBURST_M0;
    if (grant_q) begin
      w_trans = bus.HTRANS_M1;
      w_addr  = bus.HADDR_M1;
      w_write = bus.HWRITE_M1;
      w_size  = bus.HSIZE_M1;
      w_burst = bus.HBURST_M1;
    end
  end

  // Write data belongs to the data-phase owner, which lags the address owner.
  assign w_wdata = hmaster_q ? bus.HWDATA_M1 : bus.HWDATA_M0;

  // Only IDLE or a SINGLE NONSEQ can end an ownership; bursts run to completion.
  assign w_boundary = bus.HREADYOUT &&
                      ((w_trans == 2'b00) ||
                       ((w_trans == 2'b10) && (w_burst == 3'b000)));

  always_comb begin
    w_next_owner = c_DEF_MASTER;
`ifdef ARB_FIXED_PRIO_EN
    if (bus.HBUSREQ_M0)
      w_next_owner = 1'b0;
    else if (bus.HBUSREQ_M1)
      w_next_owner = 1'b1;
`else
    if (bus.HBUSREQ_M0 && bus.HBUSREQ_M1)
      w_next_owner = ~grant_q;
    else if (bus.HBUSREQ_M0)
      w_next_owner = 1'b0;
    else if (bus.HBUSREQ_M1)
      w_next_owner = 1'b1;
`endif
  end

  always_comb begin
    grant_d   = grant_q;
    hmaster_d = hmaster_q;
    if (w_boundary)
      grant_d = w_next_owner;
    if (bus.HREADYOUT)
      hmaster_d = grant_q;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      grant_q   <= c_DEF_MASTER;
      hmaster_q <= c_DEF_MASTER;
    end else begin
      grant_q   <= grant_d;
      hmaster_q <= hmaster_d;
    end
  end

  assign bus.HGRANT_M0 = ~grant_q;
  assign bus.HGRANT_M1 = grant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HSEL      = w_trans[1];
  assign bus.HTRANS    = w_trans;
  assign bus.HADDR     = w_addr;
  assign bus.HWRITE    = w_write;
  assign bus.HSIZE     = w_size;
  assign bus.HBURST    = w_burst;
  assign bus.HWDATA    = w_wdata;
  assign bus.HREADYIN  = bus.HREADYOUT;
endmodule
`default_nettype wire

// File: tb/tb_ahb_bridge_arbiter.sv
`default_nettype none
// Directed vector bench for ahb_bridge_arbiter with DEFAULT_MASTER = 0.
module tb_ahb_bridge_arbiter;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SGL = 3'b000, INCR4 = 3'b011;
  localparam logic [31:0] A0 = 32'h0000_1000, A1 = 32'h0000_2004;
  localparam logic [31:0] D0 = 32'hD0D0_0000, D1 = 32'hA5A5_0001;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FX = 1'b1;
`else
  localparam bit FX = 1'b0;
`endif

  typedef struct {
    logic       req0, req1;
    logic [1:0] tr0;
    logic [2:0] bu0;
    logic [1:0] tr1;
    logic [2:0] bu1;
    logic       rdy;
    logic       eg, em;
  } vec_t;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  ahb_bridge_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ahb_bridge_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEFAULT_MASTER(0)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.HBUSREQ_M0 = v.req0;
    bus.HBUSREQ_M1 = v.req1;
    bus.HTRANS_M0  = v.tr0;
    bus.HBURST_M0  = v.bu0;
    bus.HTRANS_M1  = v.tr1;
    bus.HBURST_M1  = v.bu1;
    bus.HREADYOUT  = v.rdy;
  endtask

  initial begin
    logic [1:0] otr;
    // inputs, then grant and data owner expected after the edge
    vecs.push_back('{0, 1, IDLE, SGL,   NSQ,  SGL, 1, 1, 0});   // M1 granted
    vecs.push_back('{0, 0, IDLE, SGL,   NSQ,  SGL, 1, 0, 1});   // M1 data phase, park
    vecs.push_back('{0, 0, IDLE, SGL,   IDLE, SGL, 1, 0, 0});
    vecs.push_back('{1, 1, NSQ,  INCR4, IDLE, SGL, 1, 0, 0});   // burst beat 0
    vecs.push_back('{1, 1, SEQ,  INCR4, IDLE, SGL, 1, 0, 0});
    vecs.push_back('{1, 1, BUSY, INCR4, IDLE, SGL, 1, 0, 0});
    vecs.push_back('{1, 1, SEQ,  INCR4, IDLE, SGL, 1, 0, 0});
    vecs.push_back('{1, 1, SEQ,  INCR4, IDLE, SGL, 1, 0, 0});
    vecs.push_back('{0, 1, IDLE, SGL,   IDLE, SGL, 1, 1, 0});   // handover after IDLE
    vecs.push_back('{1, 1, NSQ,  SGL,   NSQ,  SGL, 1, 0, 1});
    vecs.push_back('{1, 1, NSQ,  SGL,   NSQ,  SGL, 1, FX ? 1'b0 : 1'b1, 0});
    vecs.push_back('{1, 1, NSQ,  SGL,   NSQ,  SGL, 1, 0, FX ? 1'b0 : 1'b1});
    vecs.push_back('{1, 1, NSQ,  SGL,   NSQ,  SGL, 1, FX ? 1'b0 : 1'b1, 0});
    vecs.push_back('{1, 0, NSQ,  SGL,   NSQ,  SGL, 1, 0, FX ? 1'b0 : 1'b1});
    vecs.push_back('{0, 1, IDLE, SGL,   IDLE, SGL, 0, 0, FX ? 1'b0 : 1'b1}); // waits
    vecs.push_back('{0, 1, IDLE, SGL,   IDLE, SGL, 0, 0, FX ? 1'b0 : 1'b1});
    vecs.push_back('{0, 1, IDLE, SGL,   IDLE, SGL, 0, 0, FX ? 1'b0 : 1'b1});
    vecs.push_back('{0, 1, IDLE, SGL,   IDLE, SGL, 1, 1, 0});
    vecs.push_back('{0, 0, IDLE, SGL,   IDLE, SGL, 1, 0, 1});

    bus.HADDR_M0 = A0;  bus.HADDR_M1 = A1;
    bus.HWDATA_M0 = D0; bus.HWDATA_M1 = D1;
    bus.HWRITE_M0 = 1'b0; bus.HWRITE_M1 = 1'b1;
    bus.HSIZE_M0 = 3'b010; bus.HSIZE_M1 = 3'b010;
    drive('{0, 0, IDLE, SGL, IDLE, SGL, 1, 0, 0});

    // reset state
    #1;
    chk("rst_grant_m0", bus.HGRANT_M0, 1);
    chk("rst_grant_m1", bus.HGRANT_M1, 0);
    chk("rst_hmaster", bus.HMASTER, 0);
    chk("rst_haddr", bus.HADDR, A0);
    chk("rst_hsel", bus.HSEL, 0);
    chk("rst_hreadyin", bus.HREADYIN, 1);
    @(negedge HCLK);
    HRESET = 1'b0;

    foreach (vecs[i]) begin
      @(negedge HCLK);
      drive(vecs[i]);
      @(posedge HCLK);
      #1;
      otr = vecs[i].eg ? vecs[i].tr1 : vecs[i].tr0;
      chk($sformatf("v%0d_grant_m0", i), bus.HGRANT_M0, !vecs[i].eg);
      chk($sformatf("v%0d_grant_m1", i), bus.HGRANT_M1, vecs[i].eg);
      chk($sformatf("v%0d_hmaster", i), bus.HMASTER, vecs[i].em);
      chk($sformatf("v%0d_haddr", i), bus.HADDR, vecs[i].eg ? A1 : A0);
      chk($sformatf("v%0d_hwdata", i), bus.HWDATA, vecs[i].em ? D1 : D0);
      chk($sformatf("v%0d_hsel", i), bus.HSEL, otr[1]);
      chk($sformatf("v%0d_hreadyin", i), bus.HREADYIN, vecs[i].rdy);
    end

    // M1 takes the bus and starts a burst, then reset lands mid-cycle
    @(negedge HCLK);
    drive('{0, 1, IDLE, SGL, IDLE, SGL, 1, 0, 0});
    @(posedge HCLK); #1;
    chk("seq_m1_grant", bus.HGRANT_M1, 1);
    @(negedge HCLK);
    drive('{0, 1, IDLE, SGL, NSQ, INCR4, 1, 0, 0});
    @(posedge HCLK); #1;
    chk("seq_m1_hmaster", bus.HMASTER, 1);
    chk("seq_m1_hwrite", bus.HWRITE, 1);
    @(negedge HCLK);
    drive('{0, 1, IDLE, SGL, SEQ, INCR4, 1, 0, 0});
    #1;
    HRESET = 1'b1;
    #1;
    chk("async_rst_grant_m0", bus.HGRANT_M0, 1);
    chk("async_rst_grant_m1", bus.HGRANT_M1, 0);
    chk("async_rst_hmaster", bus.HMASTER, 0);
    chk("async_rst_haddr", bus.HADDR, A0);
    #1;
    HRESET = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
